// File: rtl/instr_cache_set_multi.sv
// instr_cache_set_multi: one set of an E-way set-associative instruction cache
// with B-byte blocks and true-LRU replacement. A lookup is a combinational
// tag compare that returns one word-aligned 32-bit instruction on a hit. A miss
// refills the victim way over B/8 beats from a 64-bit refill bus.
//
// Refill handshake: RepReady is the valid strobe for RepWord. There is no
// ready back-pressure. Each rising edge with ActiveSet=1, no hit and
// RepReady=1 consumes one doubleword, lowest address first. Any edge without
// such a beat restarts the refill at beat 0.
//
// Optional feature: define INSTR_CACHE_SET_PERF_CNT_EN to add the HitCount
// and FillCount performance counters.
module instr_cache_set_multi #(
   parameter int B          = 64,
   parameter int NumTagBits = 26,
   parameter int E          = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ActiveSet,
   input  logic                  RepReady,
   input  logic [$clog2(B)-1:0]  Block,
   input  logic [NumTagBits-1:0] Tag,
   input  logic [63:0]           RepWord,
   output logic [31:0]           Data,
   output logic                  CacheMiss
`ifdef INSTR_CACHE_SET_PERF_CNT_EN
   ,
   output logic [31:0]           HitCount,
   output logic [31:0]           FillCount
`endif
);

   localparam int BEATS = B / 8;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW    = $clog2(E);
   localparam int OW    = $clog2(B);

   logic [E-1:0]          valid;
   logic [NumTagBits-1:0] tags   [E];
   logic [B*8-1:0]        blocks [E];
   logic [AW-1:0]         ages   [E];   // 0 = most recent, E-1 = least recent
   logic [CW-1:0]         cnt;
   logic [AW-1:0]         victim_q;

   logic                  match;
   logic                  hit;
   logic [AW-1:0]         hit_way;
   logic [AW-1:0]         new_victim;
   logic [AW-1:0]         fill_way;
   logic                  fill;
   logic                  fill_first;
   logic                  fill_last;
   logic                  touch;
   logic [AW-1:0]         touch_way;
   logic [AW-1:0]         touch_age;
   logic [B*8-1:0]        hit_block;
   logic [OW-3:0]         word_sel;

   // Tag compare across all ways; at most one valid way can match.
   always_comb begin
      match   = 1'b0;
      hit_way = '0;
      for (int i = 0; i < E; i++) begin
         if (valid[i] && (tags[i] == Tag)) begin
            match   = 1'b1;
            hit_way = AW'(i);
         end
      end
      hit = ActiveSet & match;
   end

   // Block[1:0] is dropped so the returned word is always word-aligned.
   assign word_sel  = Block[OW-1:2];
   assign hit_block = blocks[hit_way];
   assign Data      = hit ? hit_block[{word_sel, 5'b0} +: 32] : 32'h0;
   assign CacheMiss = ~hit;

   // Victim choice: the lowest invalid way wins, otherwise the least recent way.
   always_comb begin
      new_victim = '0;
      for (int i = 0; i < E; i++) begin
         if (ages[i] == AW'(E - 1)) new_victim = AW'(i);
      end
      for (int i = E - 1; i >= 0; i--) begin
         if (!valid[i]) new_victim = AW'(i);
      end
   end

   // The victim is chosen on the first beat and then held until completion.
   assign fill       = ActiveSet & ~match & RepReady;
   assign fill_first = (cnt == '0);
   assign fill_last  = (cnt == CW'(BEATS - 1));
   assign fill_way   = fill_first ? new_victim : victim_q;
   assign touch      = hit | (fill & fill_last);
   assign touch_way  = hit ? hit_way : fill_way;
   assign touch_age  = ages[touch_way];

   // Valid bits, beat counter, latched victim and LRU ages.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid    <= '0;
         cnt      <= '0;
         victim_q <= '0;
         for (int i = 0; i < E; i++) ages[i] <= AW'(i);
      end else begin
         if (fill) begin
            // Invalidate on the first beat so a partly written block never hits.
            if (fill_first) begin
               valid[fill_way] <= 1'b0;
               victim_q        <= fill_way;
            end
            if (fill_last) begin
               valid[fill_way] <= 1'b1;
               cnt             <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
         if (touch) begin
            for (int i = 0; i < E; i++) begin
               if (AW'(i) == touch_way) ages[i] <= '0;
               else if (ages[i] < touch_age) ages[i] <= ages[i] + 1'b1;
            end
         end
      end
   end

   // Block data and tag storage; the tag is written with the last beat.
   always_ff @(posedge clk) begin
      if (reset && fill) begin
         blocks[fill_way][{cnt, 6'b0} +: 64] <= RepWord;
         if (fill_last) tags[fill_way] <= Tag;
      end
   end

`ifdef INSTR_CACHE_SET_PERF_CNT_EN
   // Hit and completed-refill counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!reset) begin
         HitCount  <= '0;
         FillCount <= '0;
      end else begin
         if (hit) HitCount <= HitCount + 32'd1;
         if (fill && fill_last) FillCount <= FillCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_cache_set_multi.sv
// Testbench for instr_cache_set_multi (default parameters B=64, E=4, 26-bit tags).
// The reference model keeps the LRU state as a recency-ordered queue of ways,
// with the most recent way at the front.
module tb_instr_cache_set_multi;

   localparam int B     = 64;
   localparam int NTB   = 26;
   localparam int E     = 4;
   localparam int BEATS = B / 8;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        active_set = 1'b0;
   logic        rep_ready = 1'b0;
   logic [5:0]  block = '0;
   logic [25:0] tag = '0;
   logic [63:0] rep_word = '0;
   logic [31:0] data;
   logic        cache_miss;
`ifdef INSTR_CACHE_SET_PERF_CNT_EN
   logic [31:0] hit_count;
   logic [31:0] fill_count;
`endif

   always #5 clk = ~clk;

   instr_cache_set_multi #(.B(B), .NumTagBits(NTB), .E(E)) dut (
      .clk       (clk),
      .reset     (reset),
      .ActiveSet (active_set),
      .RepReady  (rep_ready),
      .Block     (block),
      .Tag       (tag),
      .RepWord   (rep_word),
      .Data      (data),
      .CacheMiss (cache_miss)
`ifdef INSTR_CACHE_SET_PERF_CNT_EN
      ,
      .HitCount  (hit_count),
      .FillCount (fill_count)
`endif
   );

   int vectors = 0;
   int errors  = 0;

   // ---------------- reference model ----------------
   bit          m_valid [E];
   logic [25:0] m_tag   [E];
   logic [63:0] m_data  [E][BEATS];
   int          m_order [$];
   int          m_cnt = 0;
   int          m_victim = 0;

   logic [63:0] pat [4][BEATS];
   logic [25:0] fill_tags [4] = '{26'd500, 26'd600, 26'd700, 26'd800};

   function automatic int m_lookup(input logic [25:0] t);
      for (int i = 0; i < E; i++) if (m_valid[i] && m_tag[i] == t) return i;
      return -1;
   endfunction

   function automatic void m_touch(input int w);
      for (int i = 0; i < m_order.size(); i++) begin
         if (m_order[i] == w) begin
            m_order.delete(i);
            break;
         end
      end
      m_order.push_front(w);
   endfunction

   function automatic int m_pick();
      for (int i = 0; i < E; i++) if (!m_valid[i]) return i;
      return m_order[m_order.size() - 1];
   endfunction

   function automatic void m_expect(output logic miss, output logic [31:0] d);
      int w;
      int boff;
      logic [63:0] dw;
      w    = active_set ? m_lookup(tag) : -1;
      miss = 1'b1;
      d    = 32'h0;
      if (w >= 0) begin
         boff = int'(block) & 'h3C;
         dw   = m_data[w][boff / 8];
         miss = 1'b0;
         d    = (boff % 8 == 4) ? dw[63:32] : dw[31:0];
      end
   endfunction

   // Advance the model by one rising edge using the currently driven inputs.
   function automatic void m_edge();
      int w;
      if (!reset) begin
         for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
         m_order.delete();
         for (int i = 0; i < E; i++) m_order.push_back(i);
         m_cnt = 0;
         return;
      end
      if (!active_set) begin
         m_cnt = 0;
         return;
      end
      w = m_lookup(tag);
      if (w >= 0) begin
         m_touch(w);
         m_cnt = 0;
      end else if (rep_ready) begin
         if (m_cnt == 0) begin
            m_victim = m_pick();
            m_valid[m_victim] = 1'b0;
         end
         m_data[m_victim][m_cnt] = rep_word;
         if (m_cnt == BEATS - 1) begin
            m_tag[m_victim]   = tag;
            m_valid[m_victim] = 1'b1;
            m_touch(m_victim);
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else begin
         m_cnt = 0;
      end
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic rst, input logic act, input logic rr,
                        input logic [5:0] blk, input logic [25:0] tg,
                        input logic [63:0] wd);
      @(negedge clk);
      reset      = rst;
      active_set = act;
      rep_ready  = rr;
      block      = blk;
      tag        = tg;
      rep_word   = wd;
      #1;
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic em;
      logic [31:0] ed;
      drive(1'b0, 1'b0, 1'b0, 6'd0, 26'd0, 64'd0);
      m_edge();
      drive(1'b0, 1'b1, 1'b1, 6'd0, 26'd500, 64'h1234);
      m_edge();
      drive(1'b1, 1'b0, 1'b0, 6'd0, 26'd500, 64'd0);
      vectors++;
      if (cache_miss !== 1'b1 || data !== 32'h0) begin
         errors++;
         $display("FAIL reset_inactive: miss=%0b data=%h, expected miss=1 data=00000000", cache_miss, data);
      end
      m_edge();
      drive(1'b1, 1'b1, 1'b0, 6'd0, 26'd500, 64'd0);
      m_expect(em, ed);
      vectors++;
      if (cache_miss !== em || data !== ed || cache_miss !== 1'b1) begin
         errors++;
         $display("FAIL reset_cold_lookup: miss=%0b data=%h, expected miss=1 data=%h", cache_miss, data, ed);
      end
      m_edge();
   endtask

   task automatic test_cold_fill();
      logic em;
      logic [31:0] ed;
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < BEATS; k++) pat[t][k] = rand64();
         for (int k = 0; k < BEATS; k++) begin
            drive(1'b1, 1'b1, 1'b1, 6'd0, fill_tags[t], pat[t][k]);
            m_expect(em, ed);
            vectors++;
            if (cache_miss !== em || data !== ed) begin
               errors++;
               $display("FAIL cold_fill_beat t=%0d k=%0d: miss=%0b data=%h, expected miss=%0b data=%h",
                        t, k, cache_miss, data, em, ed);
            end
            m_edge();
         end
         drive(1'b1, 1'b1, 1'b0, 6'd0, fill_tags[t], 64'd0);
         vectors++;
         if (cache_miss !== 1'b0 || data !== pat[t][0][31:0]) begin
            errors++;
            $display("FAIL cold_fill_hit t=%0d: miss=%0b data=%h, expected miss=0 data=%h",
                     t, cache_miss, data, pat[t][0][31:0]);
         end
         m_edge();
      end
   endtask

   task automatic test_hit_reads();
      int blks [4] = '{4, 8, 12, 16};
      logic [63:0] w64;
      logic [31:0] exp_d;
      logic em;
      logic [31:0] ed;
      for (int i = 0; i < 4; i++) begin
         w64   = pat[3 - i][blks[i] / 8];
         exp_d = (blks[i] % 8 == 4) ? w64[63:32] : w64[31:0];
         drive(1'b1, 1'b1, 1'b0, 6'(blks[i]), fill_tags[3 - i], 64'd0);
         m_expect(em, ed);
         vectors++;
         if (cache_miss !== 1'b0 || data !== exp_d || data !== ed) begin
            errors++;
            $display("FAIL hit_read tag=%0d blk=%0d: miss=%0b data=%h, expected miss=0 data=%h",
                     fill_tags[3 - i], blks[i], cache_miss, data, exp_d);
         end
         m_edge();
      end
   endtask

   task automatic test_inactive();
      logic em;
      logic [31:0] ed;
      for (int c = 0; c < 64; c++) begin
         drive(1'b1, 1'b0, 1'b1, 6'($urandom_range(0, 63)),
               (c % 2 == 0) ? fill_tags[c % 4] : 26'($urandom), rand64());
         vectors++;
         if (cache_miss !== 1'b1 || data !== 32'h0) begin
            errors++;
            $display("FAIL inactive c=%0d: miss=%0b data=%h, expected miss=1 data=00000000", c, cache_miss, data);
         end
         m_edge();
      end
      // Contents and recency unchanged: re-read in the same order as before.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 6'd0, fill_tags[3 - i], 64'd0);
         m_expect(em, ed);
         vectors++;
         if (cache_miss !== 1'b0 || data !== pat[3 - i][0][31:0] || data !== ed) begin
            errors++;
            $display("FAIL inactive_keep tag=%0d: miss=%0b data=%h, expected miss=0 data=%h",
                     fill_tags[3 - i], cache_miss, data, pat[3 - i][0][31:0]);
         end
         m_edge();
      end
   endtask

   // Fill 'tg' with fresh data and check every beat plus the completion hit.
   task automatic test_lru_replace();
      logic [63:0] npat [BEATS];
      logic em;
      logic [31:0] ed;
      logic [25:0] ptags [4] = '{26'd800, 26'd600, 26'd700, 26'd500};
      logic        pmiss [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < BEATS; k++) npat[k] = rand64();
         for (int k = 0; k < BEATS; k++) begin
            drive(1'b1, 1'b1, 1'b1, 6'd0, (r == 0) ? 26'd1000 : 26'd1100, npat[k]);
            m_expect(em, ed);
            vectors++;
            if (cache_miss !== 1'b1 || em !== 1'b1) begin
               errors++;
               $display("FAIL lru_fill_beat r=%0d k=%0d: miss=%0b, expected miss=1", r, k, cache_miss);
            end
            m_edge();
         end
         drive(1'b1, 1'b1, 1'b0, 6'd20, (r == 0) ? 26'd1000 : 26'd1100, 64'd0);
         vectors++;
         if (cache_miss !== 1'b0 || data !== npat[2][63:32]) begin
            errors++;
            $display("FAIL lru_fill_hit r=%0d: miss=%0b data=%h, expected miss=0 data=%h",
                     r, cache_miss, data, npat[2][63:32]);
         end
         m_edge();
         // First round: way 3 (tag 800) evicted, then 600 touched.
         // Second round: way 2 (tag 700) is now least recent and gets evicted.
         for (int p = 2 * r; p < 2 * r + 2; p++) begin
            drive(1'b1, 1'b1, 1'b0, 6'd0, ptags[p], 64'd0);
            m_expect(em, ed);
            vectors++;
            if (cache_miss !== pmiss[p] || cache_miss !== em || data !== ed) begin
               errors++;
               $display("FAIL lru_probe tag=%0d: miss=%0b data=%h, expected miss=%0b data=%h",
                        ptags[p], cache_miss, data, pmiss[p], ed);
            end
            m_edge();
         end
      end
   endtask

   task automatic test_interrupted();
      logic [63:0] npat [BEATS];
      logic em;
      logic [31:0] ed;
      logic [25:0] all_tags [8] = '{26'd500, 26'd600, 26'd700, 26'd800,
                                    26'd1000, 26'd1100, 26'd1200, 26'd1300};
      for (int k = 0; k < BEATS; k++) npat[k] = rand64();
      for (int c = 0; c < 3 + 1 + BEATS; c++) begin
         if (c < 3)       drive(1'b1, 1'b1, 1'b1, 6'd0, 26'd1200, rand64());
         else if (c == 3) drive(1'b1, 1'b1, 1'b0, 6'd0, 26'd1200, rand64());
         else             drive(1'b1, 1'b1, 1'b1, 6'd0, 26'd1200, npat[c - 4]);
         m_expect(em, ed);
         vectors++;
         if (cache_miss !== 1'b1 || em !== 1'b1) begin
            errors++;
            $display("FAIL broken_fill c=%0d: miss=%0b, expected miss=1", c, cache_miss);
         end
         m_edge();
      end
      drive(1'b1, 1'b1, 1'b0, 6'd60, 26'd1200, 64'd0);
      vectors++;
      if (cache_miss !== 1'b0 || data !== npat[7][63:32]) begin
         errors++;
         $display("FAIL broken_fill_hit: miss=%0b data=%h, expected miss=0 data=%h", cache_miss, data, npat[7][63:32]);
      end
      m_edge();
      // Reset in the middle of a fill leaves every way invalid.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 1'b1, 6'd0, 26'd1300, rand64());
         m_edge();
      end
      drive(1'b0, 1'b1, 1'b1, 6'd0, 26'd1300, rand64());
      m_edge();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 6'd0, all_tags[i], 64'd0);
         vectors++;
         if (cache_miss !== 1'b1 || data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_fill tag=%0d: miss=%0b data=%h, expected miss=1 data=00000000",
                     all_tags[i], cache_miss, data);
         end
         m_edge();
      end
   endtask

   task automatic test_random();
      logic [25:0] pool [6] = '{26'd500, 26'd600, 26'd700, 26'd800, 26'd1000, 26'd42};
      logic em;
      logic [31:0] ed;
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 9) < 7), 6'($urandom_range(0, 63)),
               pool[$urandom_range(0, 5)], rand64());
         m_expect(em, ed);
         vectors++;
         if (cache_miss !== em || data !== ed) begin
            errors++;
            $display("FAIL random c=%0d tag=%0d blk=%0d: miss=%0b data=%h, expected miss=%0b data=%h",
                     c, tag, block, cache_miss, data, em, ed);
         end
         m_edge();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_cold_fill();
      test_hit_reads();
      test_inactive();
      test_lru_replace();
      test_interrupted();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
